// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: time-multiplexes up to four HC-SR04 rangers. It triggers one
// sensor at a time in round-robin order, times that sensor's echo pulse, converts the
// width to centimetres and reports one result per slot. Trigger rises are spaced by a
// fixed quiet gap so a late echo from one sensor cannot land in the next sensor's slot.
//
// Ports:
//   clk_125mhz     in   system clock
//   reset          in   synchronous, active-high
//   enable         in   run scheduling while high (sampled in IDLE and at end of GAP)
//   echo           in   raw asynchronous echo pins, one per sensor
//   trig           out  trigger pins, at most one high at a time
//   result_valid   out  one-cycle pulse while a slot result is presented
//   result_sensor  out  sensor index of the last result (held)
//   result_cm      out  distance in cm of the last result, 0 on timeout (held)
//   result_timeout out  last slot had no valid echo (held)
//   busy           out  high whenever the scheduler is not idle
module ultrasonic_scheduler #(
   parameter int unsigned NUM_SENSORS  = 3,
   parameter int unsigned TICKS_PER_US = 125,
   parameter int unsigned TRIG_US      = 10,
   parameter int unsigned TIMEOUT_US   = 30000,
   parameter int unsigned GAP_US       = 60000,
   parameter int unsigned US_PER_CM    = 58
) (
   input  logic                   clk_125mhz,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] echo,
   output logic [NUM_SENSORS-1:0] trig,
   output logic                   result_valid,
   output logic [1:0]             result_sensor,
   output logic [15:0]            result_cm,
   output logic                   result_timeout,
   output logic                   busy
);

   localparam int unsigned IDX_W    = 2;
   localparam int unsigned CM_W     = 16;
   localparam int unsigned PRE_W    = $clog2(TICKS_PER_US + 1);
   localparam int unsigned SLOT_MAX = (GAP_US > TIMEOUT_US) ? GAP_US : TIMEOUT_US;
   localparam int unsigned SLOT_W   = $clog2(SLOT_MAX + 1);
   localparam int unsigned SUB_W    = $clog2(US_PER_CM + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_REPORT,
      S_GAP
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       idx_next;
   logic [NUM_SENSORS-1:0] trig_next;
   logic                   report_timeout;
   logic                   rise_take;

   logic [NUM_SENSORS-1:0] echo_meta;
   logic [NUM_SENSORS-1:0] echo_sync;
   logic                   echo_sel;
   logic                   echo_sel_q;
   logic                   echo_rise;
   logic                   echo_fall;

   logic [PRE_W-1:0]       pre_cnt;
   logic                   tick;
   logic [SLOT_W-1:0]      slot_us;
   logic                   trig_entry;
   logic                   trig_done;
   logic                   timeout_hit;
   logic                   gap_done;

   logic [SUB_W-1:0]       sub_us;
   logic [CM_W-1:0]        cm_cnt;
   logic [SUB_W-1:0]       sub_base;
   logic [CM_W-1:0]        cm_base;
   logic                   count_en;

   // Two-flop synchronizer on every echo pin, plus the previous value of the selected one.
   always_ff @(posedge clk_125mhz) begin
      if (reset) begin
         echo_meta  <= '0;
         echo_sync  <= '0;
         echo_sel_q <= 1'b0;
      end else begin
         echo_meta  <= echo;
         echo_sync  <= echo_meta;
         echo_sel_q <= echo_sel;
      end
   end

   // Only the sensor owning the current slot is observed.
   always_comb begin
      echo_sel = 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (idx == IDX_W'(i)) echo_sel = echo_sync[i];
      end
   end

   assign echo_rise = echo_sel & ~echo_sel_q;
   assign echo_fall = ~echo_sel & echo_sel_q;

   assign tick        = (pre_cnt == PRE_W'(TICKS_PER_US - 1));
   assign trig_entry  = (state_next == S_TRIG) && (state != S_TRIG);
   assign trig_done   = tick && (slot_us == SLOT_W'(TRIG_US - 1));
   assign timeout_hit = (slot_us >= SLOT_W'(TIMEOUT_US));
   assign gap_done    = (slot_us >= SLOT_W'(GAP_US));

   // Microsecond prescaler and saturating slot timer, both restarted at each trigger.
   always_ff @(posedge clk_125mhz) begin
      if (reset) begin
         pre_cnt <= '0;
         slot_us <= '0;
      end else if (trig_entry) begin
         pre_cnt <= '0;
         slot_us <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick && (slot_us < SLOT_W'(GAP_US))) slot_us <= slot_us + 1'b1;
      end
   end

   // The rise cycle itself is counted (from a cleared base) so that exactly one tick is
   // seen per microsecond of synchronized high time, independent of prescaler phase.
   always_comb begin
      sub_base = rise_take ? '0 : sub_us;
      cm_base  = rise_take ? '0 : cm_cnt;
      count_en = tick && echo_sel && ((state == S_MEASURE) || rise_take);
   end

   // Echo width to centimetres: sub-counter divides microseconds by US_PER_CM.
   always_ff @(posedge clk_125mhz) begin
      if (reset) begin
         sub_us <= '0;
         cm_cnt <= '0;
      end else if (count_en) begin
         if (sub_base == SUB_W'(US_PER_CM - 1)) begin
            sub_us <= '0;
            cm_cnt <= cm_base + 1'b1;
         end else begin
            sub_us <= sub_base + 1'b1;
            cm_cnt <= cm_base;
         end
      end else begin
         sub_us <= sub_base;
         cm_cnt <= cm_base;
      end
   end

   // Next-state logic; timeout is tested before the echo edge so it wins a tie.
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      report_timeout = 1'b0;
      rise_take      = 1'b0;
      trig_next      = '0;
      case (state)
         S_IDLE: begin
            if (enable) state_next = S_TRIG;
         end
         S_TRIG: begin
            if (trig_done) state_next = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (timeout_hit) begin
               state_next     = S_REPORT;
               report_timeout = 1'b1;
            end else if (echo_rise) begin
               state_next = S_MEASURE;
               rise_take  = 1'b1;
            end
         end
         S_MEASURE: begin
            if (timeout_hit) begin
               state_next     = S_REPORT;
               report_timeout = 1'b1;
            end else if (echo_fall) begin
               state_next = S_REPORT;
            end
         end
         S_REPORT: begin
            state_next = S_GAP;
         end
         S_GAP: begin
            if (gap_done) begin
               idx_next   = (idx == IDX_W'(NUM_SENSORS - 1)) ? '0 : idx + 1'b1;
               state_next = enable ? S_TRIG : S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (state_next == S_TRIG) begin
         for (int i = 0; i < NUM_SENSORS; i++) trig_next[i] = (idx_next == IDX_W'(i));
      end
   end

   // State register and registered outputs; results hold until the next REPORT.
   always_ff @(posedge clk_125mhz) begin
      if (reset) begin
         state          <= S_IDLE;
         idx            <= '0;
         trig           <= '0;
         result_valid   <= 1'b0;
         result_sensor  <= '0;
         result_cm      <= '0;
         result_timeout <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state        <= state_next;
         idx          <= idx_next;
         trig         <= trig_next;
         result_valid <= (state_next == S_REPORT);
         busy         <= (state_next != S_IDLE);
         if (state_next == S_REPORT) begin
            result_sensor  <= idx;
            result_cm      <= report_timeout ? '0 : cm_cnt;
            result_timeout <= report_timeout;
         end
      end
   end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Bench for ultrasonic_scheduler with shortened timing (2 ticks/us, 1500 us timeout,
// 2500 us gap) so several full rounds fit in a short run. A responder plays the sensors
// and pushes the expected result for each slot; a monitor pops and compares results.
module tb_ultrasonic_scheduler;

   localparam int NS      = 3;
   localparam int TPU     = 2;
   localparam int TRIG_US = 10;
   localparam int TO_US   = 1500;
   localparam int GAP_US  = 2500;
   localparam int UPC     = 58;
   localparam int GAP_CYC = GAP_US * TPU;
   localparam int TO_CYC  = TO_US * TPU;

   typedef enum int { M_MANUAL, M_PULSE, M_SILENT } mode_e;
   typedef struct { int sensor; int cm; int to; } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [NS-1:0] echo;
   logic [NS-1:0] echo_auto;
   logic [NS-1:0] echo_manual;
   logic [NS-1:0] trig;
   logic          result_valid;
   logic [1:0]    result_sensor;
   logic [15:0]   result_cm;
   logic          result_timeout;
   logic          busy;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    results_seen;
   int    last_trig_width;
   int    echo_fall_cyc;
   exp_t  sb[$];
   int    rise_cyc[$];
   int    rise_sen[$];
   int    res_cyc[$];
   int    res_sen[$];
   mode_e mode[NS];
   int    pulse_d[NS];
   int    pulse_w[NS];

   assign echo = echo_auto | echo_manual;

   ultrasonic_scheduler #(
      .NUM_SENSORS (NS),
      .TICKS_PER_US(TPU),
      .TRIG_US     (TRIG_US),
      .TIMEOUT_US  (TO_US),
      .GAP_US      (GAP_US),
      .US_PER_CM   (UPC)
   ) dut (
      .clk_125mhz    (clk),
      .reset         (reset),
      .enable        (enable),
      .echo          (echo),
      .trig          (trig),
      .result_valid  (result_valid),
      .result_sensor (result_sensor),
      .result_cm     (result_cm),
      .result_timeout(result_timeout),
      .busy          (busy)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Watches trig rises/falls and checks each presented result against the scoreboard.
   task automatic monitor();
      logic [NS-1:0] tq;
      logic [NS-1:0] rises;
      logic          rv_q;
      int            rise_at[NS];
      exp_t          e;
      tq   = '0;
      rv_q = 1'b0;
      for (int s = 0; s < NS; s++) rise_at[s] = 0;
      forever begin
         @(negedge clk);
         rises = trig & ~tq;
         if (rises != '0) begin
            checks++;
            if ($countones(trig) > 1) begin
               failures++;
               $display("FAIL trig_onehot: trig=%b, required at most one bit high", trig);
            end
            for (int s = 0; s < NS; s++) begin
               if (rises[s]) begin
                  rise_cyc.push_back(cyc);
                  rise_sen.push_back(s);
                  rise_at[s] = cyc;
               end
            end
         end
         for (int s = 0; s < NS; s++) begin
            if (tq[s] && !trig[s]) last_trig_width = cyc - rise_at[s];
         end
         if (result_valid) begin
            checks++;
            if (rv_q) begin
               failures++;
               $display("FAIL result_valid_pulse: high for more than one cycle at cycle %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result: sensor=%0d cm=%0d timeout=%0d, none expected",
                        result_sensor, result_cm, result_timeout);
            end else begin
               e = sb.pop_front();
               checks++;
               if (result_sensor !== 2'(e.sensor)) begin
                  failures++;
                  $display("FAIL result_sensor: got %0d want %0d", result_sensor, e.sensor);
               end
               checks++;
               if (result_cm !== 16'(e.cm)) begin
                  failures++;
                  $display("FAIL result_cm: sensor %0d got %0d want %0d", e.sensor, result_cm, e.cm);
               end
               checks++;
               if (result_timeout !== 1'(e.to)) begin
                  failures++;
                  $display("FAIL result_timeout: sensor %0d got %0d want %0d", e.sensor,
                           result_timeout, e.to);
               end
            end
            res_cyc.push_back(cyc);
            res_sen.push_back(int'(result_sensor));
            results_seen++;
         end
         tq   = trig;
         rv_q = result_valid;
      end
   endtask

   // Plays the sensors: after a trigger falls, answers according to that sensor's mode
   // and pushes the result the scheduler should report for the slot.
   task automatic responder();
      logic [NS-1:0] tq;
      tq = '0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < NS; s++) begin
            if (tq[s] && !trig[s] && !reset) begin
               if (mode[s] == M_PULSE) begin
                  sb.push_back('{s, pulse_w[s] / UPC, 0});
                  repeat (pulse_d[s] * TPU) @(negedge clk);
                  echo_auto[s] = 1'b1;
                  repeat (pulse_w[s] * TPU) @(negedge clk);
                  echo_auto[s] = 1'b0;
                  echo_fall_cyc = cyc;
               end else if (mode[s] == M_SILENT) begin
                  sb.push_back('{s, 0, 1});
               end
            end
         end
         tq = trig;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      enable      = 1'b0;
      echo_manual = '0;
      for (int s = 0; s < NS; s++) mode[s] = M_MANUAL;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rise_cyc.delete();
      rise_sen.delete();
      res_cyc.delete();
      res_sen.delete();
      results_seen = 0;
   endtask

   task automatic wait_results(input int n, input int limit, output bit ok);
      int t = 0;
      while (results_seen < n && t < limit) begin
         @(negedge clk);
         t++;
      end
      ok = (results_seen >= n);
   endtask

   task automatic wait_rises(input int n, input int limit, output bit ok);
      int t = 0;
      while (rise_cyc.size() < n && t < limit) begin
         @(negedge clk);
         t++;
      end
      ok = (rise_cyc.size() >= n);
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      enable      = 1'b1;
      echo_manual = '1;
      repeat (4) @(negedge clk);
      checks++;
      if (trig !== '0) begin failures++; $display("FAIL reset_trig: got %b want 0", trig); end
      checks++;
      if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", result_valid); end
      checks++;
      if (result_sensor !== 2'd0) begin failures++; $display("FAIL reset_sensor: got %0d want 0", result_sensor); end
      checks++;
      if (result_cm !== 16'd0) begin failures++; $display("FAIL reset_cm: got %0d want 0", result_cm); end
      checks++;
      if (result_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", result_timeout); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      enable      = 1'b0;
      echo_manual = '0;
      reset       = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || trig !== '0) begin
         failures++;
         $display("FAIL idle_disabled: busy=%b trig=%b want busy=0 trig=0", busy, trig);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int lat;
      do_reset();
      mode[0]    = M_PULSE;
      pulse_d[0] = 200;
      pulse_w[0] = 1160;
      enable     = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
      wait_results(1, 2 * GAP_CYC, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_result: no result within %0d cycles", 2 * GAP_CYC);
      end else begin
         checks++;
         if (last_trig_width != TRIG_US * TPU) begin
            failures++;
            $display("FAIL basic_trig_width: got %0d cycles want %0d", last_trig_width, TRIG_US * TPU);
         end
         lat = res_cyc[0] - echo_fall_cyc;
         checks++;
         if (lat < 3 || lat > 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles want 3..4", lat);
         end
      end
      repeat (10) @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || result_cm !== 16'd20 || result_sensor !== 2'd0) begin
         failures++;
         $display("FAIL basic_hold: valid=%b cm=%0d sensor=%0d want 0/20/0", result_valid,
                  result_cm, result_sensor);
      end
      enable = 1'b0;
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL basic_sb_left: %0d pending want 0", sb.size()); end
   endtask

   task automatic test_round_robin();
      bit ok;
      int d;
      do_reset();
      for (int s = 0; s < NS; s++) begin
         mode[s]    = M_PULSE;
         pulse_d[s] = 200;
      end
      pulse_w[0] = 580;
      pulse_w[1] = 1160;
      pulse_w[2] = 290;
      enable     = 1'b1;
      wait_results(3, 4 * GAP_CYC, ok);
      for (int s = 0; s < NS; s++) mode[s] = M_MANUAL;
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_results: got %0d want 3", results_seen); end
      wait_rises(4, 2 * GAP_CYC, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rr_rises: got %0d trigger rises want 4", rise_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rise_sen[i] != i % NS) begin
               failures++;
               $display("FAIL rr_order: rise %0d on sensor %0d want %0d", i, rise_sen[i], i % NS);
            end
         end
         for (int i = 0; i < 3; i++) begin
            d = rise_cyc[i+1] - rise_cyc[i];
            checks++;
            if (d < GAP_CYC || d > GAP_CYC + 2) begin
               failures++;
               $display("FAIL rr_spacing: rise %0d to %0d is %0d cycles want %0d..%0d", i, i + 1, d,
                        GAP_CYC, GAP_CYC + 2);
            end
         end
      end
      enable = 1'b0;
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL rr_sb_left: %0d pending want 0", sb.size()); end
   endtask

   task automatic test_no_echo();
      bit ok;
      int d;
      do_reset();
      mode[0] = M_PULSE; pulse_d[0] = 100; pulse_w[0] = 580;
      mode[1] = M_SILENT;
      mode[2] = M_PULSE; pulse_d[2] = 100; pulse_w[2] = 116;
      enable  = 1'b1;
      wait_results(3, 4 * GAP_CYC, ok);
      for (int s = 0; s < NS; s++) mode[s] = M_MANUAL;
      checks++;
      if (!ok || rise_cyc.size() < 3) begin
         failures++;
         $display("FAIL noecho_results: got %0d results %0d rises want 3/3", results_seen, rise_cyc.size());
      end else begin
         d = res_cyc[1] - rise_cyc[1];
         checks++;
         if (res_sen[1] != 1 || d < TO_CYC || d > TO_CYC + 2) begin
            failures++;
            $display("FAIL noecho_timing: sensor %0d after %0d cycles want sensor 1 after %0d..%0d",
                     res_sen[1], d, TO_CYC, TO_CYC + 2);
         end
         d = rise_cyc[2] - rise_cyc[1];
         checks++;
         if (d < GAP_CYC || d > GAP_CYC + 2) begin
            failures++;
            $display("FAIL noecho_next_slot: %0d cycles want %0d..%0d", d, GAP_CYC, GAP_CYC + 2);
         end
      end
      enable = 1'b0;
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL noecho_sb_left: %0d pending want 0", sb.size()); end
   endtask

   task automatic test_stuck_crosstalk();
      bit ok;
      int d;
      do_reset();
      echo_manual[0] = 1'b1;
      repeat (10) @(negedge clk);
      sb.push_back('{0, 0, 1});
      enable = 1'b1;
      wait_rises(1, 100, ok);
      repeat (TRIG_US * TPU + 10) @(negedge clk);
      // Clean pulses on another sensor's pin during sensor 0's slot.
      for (int k = 0; k < 5; k++) begin
         echo_manual[2] = 1'b1;
         repeat (100 * TPU) @(negedge clk);
         echo_manual[2] = 1'b0;
         repeat (100 * TPU) @(negedge clk);
      end
      wait_results(1, 2 * GAP_CYC, ok);
      enable = 1'b0;
      checks++;
      if (!ok || rise_cyc.size() < 1) begin
         failures++;
         $display("FAIL stuck_result: no result within bound");
      end else begin
         d = res_cyc[0] - rise_cyc[0];
         checks++;
         if (d < TO_CYC || d > TO_CYC + 2) begin
            failures++;
            $display("FAIL stuck_timing: result %0d cycles after trigger want %0d..%0d", d, TO_CYC,
                     TO_CYC + 2);
         end
      end
      echo_manual = '0;
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL stuck_sb_left: %0d pending want 0", sb.size()); end
   endtask

   task automatic test_boundary();
      bit ok;
      do_reset();
      mode[0] = M_PULSE; pulse_d[0] = 100; pulse_w[0] = 57;
      mode[1] = M_PULSE; pulse_d[1] = 100; pulse_w[1] = 58;
      enable  = 1'b1;
      wait_results(2, 3 * GAP_CYC, ok);
      enable = 1'b0;
      for (int s = 0; s < NS; s++) mode[s] = M_MANUAL;
      checks++;
      if (!ok) begin failures++; $display("FAIL boundary_results: got %0d want 2", results_seen); end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL boundary_sb_left: %0d pending want 0", sb.size()); end
   endtask

   task automatic test_control();
      bit ok;
      int t;
      do_reset();
      mode[0] = M_PULSE; pulse_d[0] = 100; pulse_w[0] = 1160;
      enable  = 1'b1;
      t = 0;
      while (!echo_auto[0] && t < GAP_CYC) begin
         @(negedge clk);
         t++;
      end
      repeat (50) @(negedge clk);
      enable = 1'b0;
      wait_results(1, 2 * GAP_CYC, ok);
      mode[0] = M_MANUAL;
      checks++;
      if (!ok) begin failures++; $display("FAIL ctrl_drop_result: no result after enable drop"); end
      repeat (GAP_CYC + 100) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || trig !== '0 || rise_cyc.size() != 1) begin
         failures++;
         $display("FAIL ctrl_idle: busy=%b trig=%b rises=%0d want 0/0/1", busy, trig, rise_cyc.size());
      end
      // Resume on the next sensor, then abort its trigger with reset.
      enable = 1'b1;
      wait_rises(2, 100, ok);
      checks++;
      if (!ok || rise_sen[1] != 1) begin
         failures++;
         $display("FAIL ctrl_resume: resumed trigger missing or on wrong sensor, want sensor 1");
      end
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (trig !== '0) begin failures++; $display("FAIL ctrl_reset_trig: got %b want 0", trig); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_rises(3, 100, ok);
      checks++;
      if (!ok || rise_sen[2] != 0) begin
         failures++;
         $display("FAIL ctrl_restart: restart trigger missing or not on sensor 0");
      end
      repeat (50) @(negedge clk);
      checks++;
      if (results_seen != 1) begin
         failures++;
         $display("FAIL ctrl_abort_result: results=%0d want 1", results_seen);
      end
      enable = 1'b0;
      do_reset();
   endtask

   initial begin
      reset           = 1'b1;
      enable          = 1'b0;
      echo_auto       = '0;
      echo_manual     = '0;
      results_seen    = 0;
      last_trig_width = 0;
      echo_fall_cyc   = 0;
      for (int s = 0; s < NS; s++) begin
         mode[s]    = M_MANUAL;
         pulse_d[s] = 0;
         pulse_w[s] = 0;
      end
      fork
         monitor();
         responder();
      join_none
      test_reset();
      test_basic();
      test_round_robin();
      test_no_echo();
      test_stuck_crosstalk();
      test_boundary();
      test_control();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
- Time-multiplexes up to NUM_SENSORS HC-SR04 ultrasonic rangers on one controller: issues each sensor's trigger pulse, times its echo, converts the width to centimetres and reports one result per slot.
- Sensors are serviced strictly round-robin, with a guaranteed quiet gap between triggers so one sensor's echo cannot be picked up by the next.
- Sits between the sensor pins and the obstacle / steering logic, replacing one per-sensor interface instance per ranger.

Parameters:
- NUM_SENSORS, 3: number of sensors serviced, 1..4.
- TICKS_PER_US, 125: clock cycles per microsecond.
- TRIG_US, 10: trigger pulse width in µs.
- TIMEOUT_US, 30000: maximum µs from trigger start to echo fall before the slot is declared timed out.
- GAP_US, 60000: minimum µs from one trigger rise to the next trigger rise.
- US_PER_CM, 58: echo µs per centimetre.

Ports:
- clk_125mhz, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: run scheduling while high.
- echo, input, NUM_SENSORS: raw asynchronous echo pins.
- trig, output, NUM_SENSORS: trigger pins, at most one high at a time.
- result_valid, output, 1: one-cycle pulse when a slot result is presented.
- result_sensor, output, 2: index of the sensor the result belongs to.
- result_cm, output, 16: distance in cm.
- result_timeout, output, 1: the slot had no valid echo.
- busy, output, 1: high in any state except IDLE.

Behaviour:
- Interface: one clock, clk_125mhz; reset is synchronous and active-high.
- Reset values: every output is 0, FSM is in IDLE, sensor index is 0, all counters are 0, synchronizer flops are 0.
- A reset asserted mid-slot drops trig in the next cycle. No result is emitted for the aborted slot.
- Echo synchronization: each echo bit passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Only echo[idx] is observed. Other echo bits are ignored.
- µs tick: a prescaler counts 0..TICKS_PER_US-1 and pulses a tick on wrap. The prescaler and slot_us counter clear on entry to TRIG.
- slot_us counts µs since the trigger rose and saturates at GAP_US.
- IDLE:
  - trig is all 0.
  - If enable=1, go to TRIG next cycle.
- TRIG:
  - trig[idx]=1 for exactly TRIG_US*TICKS_PER_US cycles (1250 at defaults), then go to WAIT_RISE.
- WAIT_RISE:
  - Waits for a synchronized 0→1 edge on echo[idx]. An echo already high on entry does not count, so a stuck-high pin times out.
  - On the edge, clear the cm counter and µs-in-cm sub-counter, then go to MEASURE.
  - If slot_us reaches TIMEOUT_US first, go to REPORT with timeout set.
- MEASURE:
  - On each tick while echo is high, the sub-counter increments. When it reaches US_PER_CM it resets to 0 and the cm counter increments, so result = floor(high_us / US_PER_CM).
  - A synchronized 1→0 edge goes to REPORT with timeout clear.
  - If slot_us reaches TIMEOUT_US first, go to REPORT with timeout set.
- REPORT: one cycle.
  - result_valid=1 and result_sensor=idx.
  - result_cm = cm counter, or 0 on timeout.
  - result_timeout as set by the exit condition.
  - Then go to GAP.
- Result hold: result_sensor, result_cm and result_timeout hold their values until the next REPORT. result_valid is 1 only in REPORT.
- GAP:
  - Waits until slot_us ≥ GAP_US.
  - Then idx advances, wrapping NUM_SENSORS-1 → 0.
  - Next state is TRIG if enable=1, otherwise IDLE; idx advances in both cases.
- enable deassert mid-slot: the current slot completes through REPORT and GAP, then the FSM enters IDLE. enable is sampled only in IDLE and at the end of GAP.
- Timeout priority: if the timeout and the echo edge occur in the same cycle, the timeout wins.
- Latency: result_valid rises 3 or 4 cycles after the raw echo falls (2 for synchronizer, 1 for edge detect and transition, plus 1 to REPORT).
- Period: each slot lasts exactly GAP_US µs plus at most 2 cycles; a full round takes NUM_SENSORS slots.

Test Plan:
- Basic range: reset, enable=1; sensor 0 echo high 5800 µs starting 200 µs after trig falls -> trig[0] high exactly 1250 cycles; result_valid with sensor=0, cm=100, timeout=0.
- Round-robin and wrap:
  - Stimulus: echoes of 580 µs, 1160 µs and 2900 µs on sensors 0, 1, 2.
  - Results: sensor 0 gives cm=10, sensor 1 gives cm=20, sensor 2 gives cm=50, then the next trigger is on sensor 0 again.
  - Trigger rises are 60000 µs apart.
  - trig is never multi-hot.
- No echo: sensor 1 silent -> result at slot_us=30000 with sensor=1, cm=0, timeout=1; the next slot still starts 60000 µs after sensor 1's trigger.
- Stuck-high echo plus cross-talk:
  - echo[0] held high from before trig -> timeout=1.
  - Pulses on echo[2] during sensor 0's slot are ignored.
- Boundary: echo 57 µs -> cm=0, timeout=0; echo 58 µs -> cm=1.
- Control:
  - enable dropped during MEASURE -> that result is still reported, then IDLE with busy=0 and no further trig.
  - reset mid-TRIG -> trig=0 on the next cycle, no result_valid, restart on sensor 0.
